mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch path and its load/store path.
- Serialises the two requesters and drives each memory transaction with a req/ack handshake.
- Returns read data to the correct requester.
- Produces the core-wide stall that holds pc while any access is outstanding.
- Sits between the fetch/decode stage and the memory/bus interface.

Parameters:
- ADDR_W, 32, address width in bits.
- DATA_W, 32, data width in bits; byte enables are DATA_W/8 wide.
- TIMEOUT, 255, memAck wait cycles before a transaction faults; range 1..65535.
- STARVE_MAX, 2, consecutive data grants allowed while a fetch waits.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ifReq  in  1  fetch request; held high until ifValid.
- ifAddr  in  ADDR_W  fetch address (pc).
- ifData  out  DATA_W  registered fetched instruction.
- ifValid  out  1  one-cycle pulse; ifData valid.
- dReq  in  1  load/store request; held high until dValid.
- dWe  in  1  1 = store, 0 = load.
- dAddr  in  ADDR_W  data address.
- dWdata  in  DATA_W  store data.
- dBe  in  DATA_W/8  store byte enables.
- dRdata  out  DATA_W  registered load data.
- dValid  out  1  one-cycle pulse; load data valid or store done.
- memReq  out  1  memory transaction request.
- memWe  out  1  memory write enable.
- memAddr  out  ADDR_W  memory address.
- memWdata  out  DATA_W  memory write data.
- memBe  out  DATA_W/8  memory byte enables; all ones on reads.
- memRdata  in  DATA_W  memory read data, valid with memAck.
- memAck  in  1  memory completion, one cycle.
- stall  out  1  hold pc and instruction.
- busErr  out  1  sticky timeout fault flag.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE. memReq, memWe, ifValid, dValid and busErr are 0. memAddr, memWdata, memBe, ifData and dRdata are 0. waitCnt and starveCnt are 0.
- States: IDLE, BUSY_I, BUSY_D, FAULT.
- Eligibility: a requester is eligible in IDLE if its req is high and its own valid is not high this cycle. This blocks a regrant while the requester drops req.
- Arbitration in IDLE:
  - Only one eligible: grant it.
  - Both eligible: grant dReq unless starveCnt == STARVE_MAX, in which case grant ifReq.
  - starveCnt increments on each data grant made while ifReq is pending. It clears on any fetch grant.
- Grant edge:
  - memReq goes to 1.
  - memAddr/memWe/memWdata/memBe are loaded from the winner; a fetch loads memWe=0 and memBe all ones.
  - waitCnt goes to 0.
  - The FSM moves to BUSY_I or BUSY_D.
  - Memory outputs stay stable until the ack edge.
- BUSY_x with memAck = 1:
  - memReq goes to 0.
  - ifData/dRdata capture memRdata; stores leave dRdata unchanged.
  - ifValid or dValid is 1 for exactly the next cycle.
  - The FSM returns to IDLE.
  - Minimum latency, request to valid: grant edge, ack in the first BUSY cycle, valid the cycle after. That is 2 cycles after req is first seen in IDLE.
- BUSY_x with memAck = 0: waitCnt increments.
  - When waitCnt == TIMEOUT-1 and memAck = 0: move to FAULT, memReq goes to 0, busErr goes to 1, no valid pulse.
  - memAck in the same cycle as the timeout wins; the transaction completes normally.
- FAULT: absorbing.
  - stall is 1.
  - memReq is 0; memAck is ignored.
  - busErr is held.
  - Left only by reset.
- stall (combinational) = (state != IDLE) | ((ifReq | dReq) & !ifValid & !dValid). In a cycle with any valid pulse and a new req, stall is 1 from the following cycle.
- memAck while IDLE is ignored.
- Reset mid-transaction: the outstanding access is abandoned and no valid is produced. The memory side must tolerate memReq dropping.

Decomposition:
- Shared package (mem_pkg):
  - state encoding IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, FAULT=2'd3;
  - ADDR_W/DATA_W defaults;
  - BE_ALL constant.
- One sub-module, mem_wait_timer: waitCnt counter with clear, enable and an expired flag. Arbitration and the FSM stay in the top module.

Test Plan:
- Fetch only:
  - Stimulus: ifReq=1, ifAddr=0x100; memAck one cycle after memReq with memRdata=0x00500093.
  - Required: memAddr=0x100, memWe=0, memBe=4'hF; ifValid pulses once with ifData=0x00500093; stall is 1 until the ifValid cycle.
- Simultaneous requests:
  - Stimulus: ifReq/dReq both high, dWe=1, dAddr=0x2004, dWdata=0xDEADBEEF, dBe=4'b0011.
  - Required: store granted first with memWe=1, memBe=0011; dValid pulses; fetch is granted next; dRdata unchanged.
- Starvation guard:
  - Stimulus: ifReq held high while dReq re-asserts every cycle after dValid.
  - Required: at most 2 data grants, then a fetch grant; starveCnt returns to 0.
- Wait states:
  - Stimulus: memAck delayed 5 cycles.
  - Required: memAddr/memWdata/memBe stable all 5 cycles; valid arrives 1 cycle after ack; busErr=0.
- Timeout:
  - Stimulus: TIMEOUT=4, memAck never arrives.
  - Required: after 4 BUSY cycles, FAULT with busErr=1, memReq=0, stall=1; later memAck and requests are ignored.
- Async reset mid-access:
  - Stimulus: rst_n low between clock edges during BUSY_D.
  - Required: memReq and all other outputs zero immediately; no dValid after release; the next ifReq is served normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter.
//   - arb_state_e : arbiter FSM state encoding
//   - ADDR_W_DEF / DATA_W_DEF : default bus widths
//   - BE_ALL : all-ones byte-enable source, sliced to the byte-enable width in use
package mem_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  // Wide enough for DATA_W up to 512; users slice [BE_W-1:0].
  localparam logic [63:0] BE_ALL = '1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StBusyI = 2'd1,
    StBusyD = 2'd2,
    StFault = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for an outstanding memory transaction.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : restart the count at zero (grant edge)
//   en_i       : count one more cycle without acknowledge
//   expired_o  : count has reached TIMEOUT-1
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [15:0] wait_cnt_q, wait_cnt_d;

  assign expired_o = (wait_cnt_q == 16'(TIMEOUT - 1));

  // Holds at the expiry value so the count can never wrap past it.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr_i) begin
      wait_cnt_d = '0;
    end else if (en_i && !expired_o) begin
      wait_cnt_d = wait_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store.
//   clk, rst_n                          : clock, asynchronous active-low reset
//   ifReq/ifAddr -> ifData/ifValid      : fetch requester (req held until valid)
//   dReq/dWe/dAddr/dWdata/dBe
//                -> dRdata/dValid       : load/store requester (req held until valid)
//   memReq/memWe/memAddr/memWdata/memBe : memory transaction, stable until ack
//   memRdata/memAck                     : memory response, one-cycle ack
//   stall                               : hold pc while any access is outstanding
//   busErr                              : sticky timeout fault
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned TIMEOUT    = 255,
  parameter int unsigned STARVE_MAX = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ifReq,
  input  logic [ADDR_W-1:0]     ifAddr,
  output logic [DATA_W-1:0]     ifData,
  output logic                  ifValid,
  input  logic                  dReq,
  input  logic                  dWe,
  input  logic [ADDR_W-1:0]     dAddr,
  input  logic [DATA_W-1:0]     dWdata,
  input  logic [DATA_W/8-1:0]   dBe,
  output logic [DATA_W-1:0]     dRdata,
  output logic                  dValid,
  output logic                  memReq,
  output logic                  memWe,
  output logic [ADDR_W-1:0]     memAddr,
  output logic [DATA_W-1:0]     memWdata,
  output logic [DATA_W/8-1:0]   memBe,
  input  logic [DATA_W-1:0]     memRdata,
  input  logic                  memAck,
  output logic                  stall,
  output logic                  busErr
);

  localparam int unsigned BeW       = DATA_W / 8;
  localparam logic [7:0]  StarveMax = 8'(STARVE_MAX);

  arb_state_e          state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BeW-1:0]      mem_be_q, mem_be_d;
  logic [DATA_W-1:0]   if_data_q, if_data_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                bus_err_q, bus_err_d;
  logic [7:0]          starve_q, starve_d;

  logic if_elig, d_elig, grant_i, grant_d;
  logic timer_clr, timer_en, timer_expired;

  // A requester whose valid is pulsing this cycle is still holding the old req.
  assign if_elig = ifReq & ~if_valid_q;
  assign d_elig  = dReq & ~d_valid_q;
  assign grant_d = d_elig & (~if_elig | (starve_q != StarveMax));
  assign grant_i = if_elig & ~grant_d;

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (timer_clr),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_data_d   = if_data_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    bus_err_d   = bus_err_q;
    starve_d    = starve_q;
    timer_clr   = 1'b0;
    timer_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_d) begin
          state_d     = StBusyD;
          mem_req_d   = 1'b1;
          mem_we_d    = dWe;
          mem_addr_d  = dAddr;
          mem_wdata_d = dWdata;
          // Reads always fetch the whole word.
          mem_be_d    = dWe ? dBe : BE_ALL[BeW-1:0];
          timer_clr   = 1'b1;
          if (ifReq && (starve_q < StarveMax)) begin
            starve_d = starve_q + 8'd1;
          end
        end else if (grant_i) begin
          state_d    = StBusyI;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = ifAddr;
          mem_be_d   = BE_ALL[BeW-1:0];
          timer_clr  = 1'b1;
          starve_d   = '0;
        end
      end
      StBusyI, StBusyD: begin
        // An ack on the timeout cycle still completes the transaction.
        if (memAck) begin
          state_d   = StIdle;
          mem_req_d = 1'b0;
          if (state_q == StBusyI) begin
            if_data_d  = memRdata;
            if_valid_d = 1'b1;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) begin
              d_rdata_d = memRdata;
            end
          end
        end else if (timer_expired) begin
          state_d   = StFault;
          mem_req_d = 1'b0;
          bus_err_d = 1'b1;
        end else begin
          timer_en = 1'b1;
        end
      end
      StFault: begin
        // Absorbing; only reset leaves.
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_data_q   <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      bus_err_q   <= 1'b0;
      starve_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_data_q   <= if_data_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      bus_err_q   <= bus_err_d;
      starve_q    <= starve_d;
    end
  end

  assign memReq   = mem_req_q;
  assign memWe    = mem_we_q;
  assign memAddr  = mem_addr_q;
  assign memWdata = mem_wdata_q;
  assign memBe    = mem_be_q;
  assign ifData   = if_data_q;
  assign dRdata   = d_rdata_q;
  assign ifValid  = if_valid_q;
  assign dValid   = d_valid_q;
  assign busErr   = bus_err_q;
  assign stall    = (state_q != StIdle) | ((ifReq | dReq) & ~if_valid_q & ~d_valid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter; the bench plays both requesters and
// the memory, and predicts every output from a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned SM = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (TIMEOUT 8)
  logic        rst_n, if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_data, d_rdata, mem_addr, mem_wdata;
  logic        if_valid, d_valid, mem_req, mem_we, stall, bus_err;
  logic [3:0]  mem_be;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .STARVE_MAX(SM)) u_dut (
    .clk(clk), .rst_n(rst_n), .ifReq(if_req), .ifAddr(if_addr), .ifData(if_data),
    .ifValid(if_valid), .dReq(d_req), .dWe(d_we), .dAddr(d_addr), .dWdata(d_wdata),
    .dBe(d_be), .dRdata(d_rdata), .dValid(d_valid), .memReq(mem_req), .memWe(mem_we),
    .memAddr(mem_addr), .memWdata(mem_wdata), .memBe(mem_be), .memRdata(mem_rdata),
    .memAck(mem_ack), .stall(stall), .busErr(bus_err)
  );

  // Timeout instance (TIMEOUT 4), fetch side only
  logic        t_rst_n, t_if_req, t_mem_ack;
  logic [31:0] t_if_data, t_d_rdata, t_mem_addr, t_mem_wdata;
  logic        t_if_valid, t_d_valid, t_mem_req, t_mem_we, t_stall, t_bus_err;
  logic [3:0]  t_mem_be;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(4), .STARVE_MAX(SM)) u_dut_to (
    .clk(clk), .rst_n(t_rst_n), .ifReq(t_if_req), .ifAddr(32'h40), .ifData(t_if_data),
    .ifValid(t_if_valid), .dReq(1'b0), .dWe(1'b0), .dAddr(32'h0), .dWdata(32'h0),
    .dBe(4'h0), .dRdata(t_d_rdata), .dValid(t_d_valid), .memReq(t_mem_req),
    .memWe(t_mem_we), .memAddr(t_mem_addr), .memWdata(t_mem_wdata), .memBe(t_mem_be),
    .memRdata(32'h1234_5678), .memAck(t_mem_ack), .stall(t_stall), .busErr(t_bus_err)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  int          m_busy;          // 0 none, 1 fetch, 2 data
  int          m_wait, m_lat, m_starve;
  logic        exp_ifv, exp_dv;
  logic [31:0] exp_if_data, exp_d_rdata;
  logic        e_we;
  logic [31:0] e_addr, e_wdata;
  logic [3:0]  e_be;
  logic [31:0] mem_m [logic [31:0]];

  // Stimulus knobs
  int          p_if, p_d, lat_lo, lat_hi;
  bit          re_d;
  bit          nx_if, nx_d, nx_d_we;
  logic [31:0] nx_if_addr, nx_d_addr, nx_d_wdata;
  logic [3:0]  nx_d_be;

  // Observations of the DUT (grant order, pulse counts)
  logic [31:0] dut_log[$];
  logic        we_log[$];
  logic        prev_mem_req;
  int          n_ifv, n_dv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_m.exists(a) ? mem_m[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h2000 + ($urandom_range(7) << 2);
  endfunction

  task automatic rnd_d();
    d_req   = 1'b1;
    d_we    = 1'($urandom_range(1));
    d_addr  = rnd_addr();
    d_wdata = $urandom();
    d_be    = 4'($urandom_range(15, 1));
  endtask

  task automatic model_reset();
    m_busy = 0; m_wait = 0; m_lat = 0; m_starve = 0;
    exp_ifv = 1'b0; exp_dv = 1'b0; exp_if_data = '0; exp_d_rdata = '0;
    prev_mem_req = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, check stall, advance model.
  task automatic step();
    logic ack, ie, de, nifv, ndv;
    logic [31:0] w;
    @(negedge clk);
    chk("ifValid", {31'b0, if_valid}, {31'b0, exp_ifv});
    chk("dValid", {31'b0, d_valid}, {31'b0, exp_dv});
    chk("ifData", if_data, exp_if_data);
    chk("dRdata", d_rdata, exp_d_rdata);
    chk("memReq", {31'b0, mem_req}, {31'b0, (m_busy != 0)});
    chk("busErr", {31'b0, bus_err}, 32'h0);
    if (m_busy != 0) begin
      chk("memAddr", mem_addr, e_addr);
      chk("memWe", {31'b0, mem_we}, {31'b0, e_we});
      chk("memBe", {28'b0, mem_be}, {28'b0, e_be});
      if (m_busy == 2) chk("memWdata", mem_wdata, e_wdata);
    end
    if (mem_req === 1'b1 && prev_mem_req !== 1'b1) begin
      dut_log.push_back(mem_addr);
      we_log.push_back(mem_we);
    end
    prev_mem_req = mem_req;
    if (if_valid === 1'b1) n_ifv++;
    if (d_valid === 1'b1) n_dv++;

    // Requesters
    if (exp_ifv) begin
      if_req = (int'($urandom_range(99)) < p_if);
      if (if_req) if_addr = rnd_addr();
    end else if (nx_if) begin
      if_req = 1'b1; if_addr = nx_if_addr; nx_if = 1'b0;
    end else if (!if_req && int'($urandom_range(99)) < p_if) begin
      if_req = 1'b1; if_addr = rnd_addr();
    end
    if (exp_dv) begin
      if (re_d || int'($urandom_range(99)) < p_d) rnd_d();
      else d_req = 1'b0;
    end else if (nx_d) begin
      d_req = 1'b1; d_we = nx_d_we; d_addr = nx_d_addr; d_wdata = nx_d_wdata; d_be = nx_d_be;
      nx_d = 1'b0;
    end else if (!d_req && int'($urandom_range(99)) < p_d) begin
      rnd_d();
    end

    // Memory
    ack = (m_busy != 0) && (m_wait == m_lat);
    mem_ack = ack | ((m_busy == 0) && ($urandom_range(3) == 0));
    mem_rdata = (ack && !(m_busy == 2 && e_we)) ? mem_rd(e_addr) : $urandom();
    #1;
    chk("stall", {31'b0, stall},
        {31'b0, (m_busy != 0) | ((if_req | d_req) & ~exp_ifv & ~exp_dv)});

    // Effect of the coming edge
    nifv = 1'b0; ndv = 1'b0;
    if (m_busy != 0) begin
      if (ack) begin
        if (m_busy == 1) begin
          nifv = 1'b1; exp_if_data = mem_rdata;
        end else begin
          ndv = 1'b1;
          if (!e_we) exp_d_rdata = mem_rdata;
          else begin
            w = mem_rd(e_addr);
            for (int b = 0; b < 4; b++) if (e_be[b]) w[8*b +: 8] = e_wdata[8*b +: 8];
            mem_m[e_addr] = w;
          end
        end
        m_busy = 0;
      end else begin
        m_wait++;
      end
    end else begin
      ie = if_req & ~exp_ifv;
      de = d_req & ~exp_dv;
      if (de && (!ie || m_starve != SM)) begin
        m_busy = 2; e_we = d_we; e_addr = d_addr; e_wdata = d_wdata;
        e_be = d_we ? d_be : 4'hF;
        if (if_req && m_starve < SM) m_starve++;
      end else if (ie) begin
        m_busy = 1; e_we = 1'b0; e_addr = if_addr; e_be = 4'hF;
        m_starve = 0;
      end
      if (m_busy != 0) begin
        m_wait = 0;
        m_lat = int'($urandom_range(lat_hi, lat_lo));
      end
    end
    exp_ifv = nifv; exp_dv = ndv;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int run_d, max_run;
    bit seen_if;
    rst_n = 1'b0; t_rst_n = 1'b0; t_if_req = 1'b0; t_mem_ack = 1'b0;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    d_be = '0; mem_ack = 1'b0; mem_rdata = '0;
    p_if = 0; p_d = 0; lat_lo = 0; lat_hi = 0; re_d = 1'b0; nx_if = 1'b0; nx_d = 1'b0;
    nx_d_we = 1'b0; nx_if_addr = '0; nx_d_addr = '0; nx_d_wdata = '0; nx_d_be = '0;
    n_ifv = 0; n_dv = 0;
    model_reset();

    // Reset state
    #2;
    chk("rst_memReq", {31'b0, mem_req}, 32'h0);
    chk("rst_memAddr", mem_addr, 32'h0);
    chk("rst_memBe", {28'b0, mem_be}, 32'h0);
    chk("rst_ifData", if_data, 32'h0);
    chk("rst_busErr", {31'b0, bus_err}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1; t_rst_n = 1'b1;

    // Fetch only, ack in the first busy cycle
    mem_m[32'h100] = 32'h0050_0093;
    nx_if = 1'b1; nx_if_addr = 32'h100;
    dut_log.delete(); we_log.delete(); n_ifv = 0;
    run(6);
    chk("fetch_pulses", n_ifv, 1);
    chk("fetch_ifData", if_data, 32'h0050_0093);
    chk("fetch_grant_addr", dut_log.size() > 0 ? dut_log[0] : 32'hx, 32'h100);

    // Simultaneous fetch and store: store wins, then fetch
    nx_if = 1'b1; nx_if_addr = 32'h300;
    nx_d = 1'b1; nx_d_we = 1'b1; nx_d_addr = 32'h2004; nx_d_wdata = 32'hDEAD_BEEF;
    nx_d_be = 4'b0011;
    dut_log.delete(); we_log.delete(); lat_hi = 1;
    run(10);
    chk("simul_n_grants", dut_log.size(), 2);
    if (dut_log.size() == 2) begin
      chk("simul_first", dut_log[0], 32'h2004);
      chk("simul_first_we", {31'b0, we_log[0]}, 32'h1);
      chk("simul_second", dut_log[1], 32'h300);
    end

    // Wait states: ack after 5 busy cycles, then at the timeout boundary (7)
    lat_lo = 5; lat_hi = 5;
    nx_d = 1'b1; nx_d_we = 1'b1; nx_d_addr = 32'h2010; nx_d_wdata = 32'hA5A5_5A5A;
    nx_d_be = 4'b1100;
    run(10);
    lat_lo = 7; lat_hi = 7;
    nx_d = 1'b1; nx_d_we = 1'b0; nx_d_addr = 32'h2010;
    run(12);
    chk("late_load", d_rdata, 32'hA5A5_0000);

    // Starvation guard: fetch held while data keeps re-requesting
    lat_lo = 0; lat_hi = 3; re_d = 1'b1;
    nx_if = 1'b1; nx_if_addr = 32'h400;
    nx_d = 1'b1; nx_d_we = 1'b0; nx_d_addr = 32'h2008;
    dut_log.delete(); we_log.delete();
    run(30);
    re_d = 1'b0;
    run(15);
    run_d = 0; max_run = 0; seen_if = 1'b0;
    foreach (dut_log[i]) begin
      if (!seen_if) begin
        if (dut_log[i] == 32'h400) seen_if = 1'b1;
        else begin run_d++; if (run_d > max_run) max_run = run_d; end
      end
    end
    chk("starve_fetch_served", {31'b0, seen_if}, 32'h1);
    chk("starve_max_data_run", {31'b0, (max_run <= SM)}, 32'h1);

    // Randomized traffic
    p_if = 30; p_d = 40; lat_lo = 0; lat_hi = 4;
    run(600);
    p_if = 0; p_d = 0;
    run(20);

    // Async reset during a data access
    lat_lo = 6; lat_hi = 6;
    nx_d = 1'b1; nx_d_we = 1'b1; nx_d_addr = 32'h2018; nx_d_wdata = 32'h1111_2222;
    nx_d_be = 4'hF;
    run(3);
    chk("pre_rst_busy", {31'b0, mem_req}, 32'h1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_memReq", {31'b0, mem_req}, 32'h0);
    chk("arst_memWe", {31'b0, mem_we}, 32'h0);
    chk("arst_memAddr", mem_addr, 32'h0);
    chk("arst_memWdata", mem_wdata, 32'h0);
    chk("arst_memBe", {28'b0, mem_be}, 32'h0);
    chk("arst_dRdata", d_rdata, 32'h0);
    chk("arst_ifData", if_data, 32'h0);
    chk("arst_busErr", {31'b0, bus_err}, 32'h0);
    if_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mem_m[32'h500] = 32'hCAFE_F00D;
    lat_lo = 1; lat_hi = 1; n_dv = 0; n_ifv = 0;
    nx_if = 1'b1; nx_if_addr = 32'h500;
    run(8);
    chk("arst_no_dvalid", n_dv, 0);
    chk("arst_fetch_served", n_ifv, 1);
    chk("arst_fetch_data", if_data, 32'hCAFE_F00D);

    // Timeout on the TIMEOUT=4 instance
    @(negedge clk);
    t_if_req = 1'b1;
    #1 chk("to_stall_req", {31'b0, t_stall}, 32'h1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to_busy_memReq", {31'b0, t_mem_req}, 32'h1);
      chk("to_busy_busErr", {31'b0, t_bus_err}, 32'h0);
    end
    @(negedge clk);
    chk("to_fault_memReq", {31'b0, t_mem_req}, 32'h0);
    chk("to_fault_busErr", {31'b0, t_bus_err}, 32'h1);
    chk("to_fault_stall", {31'b0, t_stall}, 32'h1);
    t_mem_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) t_if_req = 1'b0;
      chk("to_hold_memReq", {31'b0, t_mem_req}, 32'h0);
      chk("to_hold_ifValid", {31'b0, t_if_valid}, 32'h0);
      chk("to_hold_busErr", {31'b0, t_bus_err}, 32'h1);
      #1 chk("to_hold_stall", {31'b0, t_stall}, 32'h1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
